// File: rtl/robot_if.sv
// Sensor/command bundle between the world model and the wall-following controller.
// The world (master) drives the sensor flags; the controller (slave) drives the commands.
interface robot_if;
    logic head;
    logic left;
    logic under;
    logic barrier;
    logic front;
    logic turn;
    logic remove;

    modport master (
        output head,
        output left,
        output under,
        output barrier,
        input  front,
        input  turn,
        input  remove
    );

    modport slave (
        input  head,
        input  left,
        input  under,
        input  barrier,
        output front,
        output turn,
        output remove
    );
endinterface

// File: rtl/robot_controller.sv
// Left-hand wall-following decision core: samples four sensor flags each robot tick
// and issues one registered command (front / turn / remove, or idle).
module robot_controller (
    input  logic     clock,
    input  logic     reset,
    robot_if.slave   bus
);

    typedef enum logic [2:0] {
        SEARCH  = 3'd0,
        FOLLOW  = 3'd1,
        STEP    = 3'd2,
        ROTATE  = 3'd3,
        STOPPED = 3'd4
    } state_t;

    // Two more turns follow the one issued on entry, giving a right turn.
    localparam logic [1:0] ROT_EXTRA = 2'd2;

    state_t     r_state;
    logic [1:0] r_rot_cnt;
    logic       r_front;
    logic       r_turn;
    logic       r_remove;

    state_t     w_next_state;
    state_t     w_mode;
    logic [1:0] w_next_rot_cnt;
    logic       w_front;
    logic       w_turn;
    logic       w_remove;

    // A wall on the left while searching means the wall is already found.
    assign w_mode = (r_state == SEARCH && bus.left) ? FOLLOW : r_state;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_next_state   = r_state;
        w_next_rot_cnt = r_rot_cnt;
        w_front        = 1'b0;
        w_turn         = 1'b0;
        w_remove       = 1'b0;

        if (r_state == STOPPED || bus.under) begin
            w_next_state = STOPPED;
        end else if (bus.barrier) begin
            w_remove = 1'b1;
        end else begin
            unique case (w_mode)
                SEARCH: begin
                    if (!bus.head) begin
                        w_front = 1'b1;
                    end else begin
                        w_turn         = 1'b1;
                        w_next_rot_cnt = ROT_EXTRA;
                        w_next_state   = ROTATE;
                    end
                end
                FOLLOW: begin
                    if (!bus.left) begin
                        w_turn       = 1'b1;
                        w_next_state = STEP;
                    end else if (!bus.head) begin
                        w_front      = 1'b1;
                        w_next_state = FOLLOW;
                    end else begin
                        w_turn         = 1'b1;
                        w_next_rot_cnt = ROT_EXTRA;
                        w_next_state   = ROTATE;
                    end
                end
                STEP: begin
                    if (!bus.head) begin
                        w_front      = 1'b1;
                        w_next_state = FOLLOW;
                    end else begin
                        w_turn         = 1'b1;
                        w_next_rot_cnt = ROT_EXTRA;
                        w_next_state   = ROTATE;
                    end
                end
                ROTATE: begin
                    w_turn = 1'b1;
                    if (r_rot_cnt <= 2'd1) begin
                        w_next_rot_cnt = 2'd0;
                        w_next_state   = FOLLOW;
                    end else begin
                        w_next_rot_cnt = r_rot_cnt - 2'd1;
                    end
                end
                default: begin
                    w_next_state = SEARCH;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= SEARCH;
            r_rot_cnt <= 2'd0;
            r_front   <= 1'b0;
            r_turn    <= 1'b0;
            r_remove  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values together.
            r_state   <= w_next_state;
            r_rot_cnt <= w_next_rot_cnt;
            r_front   <= w_front;
            r_turn    <= w_turn;
            r_remove  <= w_remove;
        end
    end

    assign bus.front  = r_front;
    assign bus.turn   = r_turn;
    assign bus.remove = r_remove;

endmodule

// File: tb/tb_robot_controller.sv
// Directed scoreboard bench for robot_controller: expected commands are queued when
// sensors are driven and popped when the registered command appears.
module tb_robot_controller;

    localparam logic [2:0] Z = 3'b000;
    localparam logic [2:0] F = 3'b100;
    localparam logic [2:0] T = 3'b010;
    localparam logic [2:0] R = 3'b001;

    logic clock;
    logic reset;
    robot_if bus ();

    int checks   = 0;
    int failures = 0;

    logic [2:0] exp_q [$];
    string      tag_q [$];

    robot_controller dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic compare();
        logic [2:0] obs;
        logic [2:0] exp;
        string      tag;
        obs = {bus.front, bus.turn, bus.remove};
        exp = exp_q.pop_front();
        tag = tag_q.pop_front();
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed={front,turn,remove}=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step(input logic h, input logic l, input logic u, input logic b,
                        input logic [2:0] exp, input string tag);
        @(negedge clock);
        bus.head    = h;
        bus.left    = l;
        bus.under   = u;
        bus.barrier = b;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge clock);
        #1;
        compare();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "timeout");
    end

    initial begin
        reset       = 1'b0;
        bus.head    = 1'b0;
        bus.left    = 1'b0;
        bus.under   = 1'b0;
        bus.barrier = 1'b0;

        // Reset held with random sensors: outputs stay idle.
        for (int i = 0; i < 4; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), Z, "reset_hold");
        bus.head = 1'b0; bus.left = 1'b0; bus.under = 1'b0; bus.barrier = 1'b0;
        reset = 1'b1;

        // Search forward, then wall ahead forces a three-turn right turn.
        step(0, 0, 0, 0, F, "search_front0");
        step(0, 0, 0, 0, F, "search_front1");
        step(0, 0, 0, 0, F, "search_front2");
        step(1, 0, 0, 0, T, "search_wall_turn0");
        step(1, 0, 0, 0, T, "rotate_turn1");
        step(0, 0, 0, 0, T, "rotate_turn2");
        step(0, 1, 0, 0, F, "follow_front");

        // Left opening: turn once, then must advance even with left still open.
        step(0, 0, 0, 0, T, "left_open_turn");
        step(0, 0, 0, 0, F, "step_front");

        // Corner: exactly three turns, sensors ignored mid-rotation.
        step(1, 1, 0, 0, T, "corner_turn0");
        step(1, 1, 0, 0, T, "corner_turn1");
        step(1, 1, 0, 0, T, "corner_turn2");
        step(0, 1, 0, 0, F, "corner_front");

        // Trash during rotation: removal holds rotation progress.
        step(1, 1, 0, 0, T, "trash_turn0");
        for (int i = 0; i < 6; i++)
            step(1, 1, 0, 1, R, "trash_remove");
        step(1, 1, 0, 0, T, "trash_turn1");
        step(0, 0, 0, 0, T, "trash_turn2");
        step(0, 1, 0, 0, F, "trash_front");

        // Left turn into a wall: STEP with head=1 starts a right turn.
        step(0, 0, 0, 0, T, "step_left_turn");
        step(1, 0, 0, 0, T, "step_wall_turn0");
        step(0, 0, 0, 0, T, "step_wall_turn1");
        step(0, 0, 0, 0, T, "step_wall_turn2");
        step(0, 1, 0, 0, F, "step_wall_front");

        // Barrier in FOLLOW, then resume following.
        step(1, 1, 0, 1, R, "follow_remove");
        step(0, 1, 0, 0, F, "follow_resume");

        // Mid-rotation asynchronous reset clears outputs immediately.
        step(1, 1, 0, 0, T, "pre_reset_turn");
        reset = 1'b0;
        #1;
        exp_q.push_back(Z);
        tag_q.push_back("async_reset");
        compare();
        step(1, 1, 0, 0, Z, "reset_hold_mid");
        bus.head = 1'b1; bus.left = 1'b1; bus.under = 1'b0; bus.barrier = 1'b0;
        reset = 1'b1;

        // SEARCH with head and left: left wins, corner handling applies.
        step(1, 1, 0, 0, T, "search_corner_turn0");
        step(0, 0, 0, 0, T, "search_corner_turn1");
        step(0, 0, 0, 0, T, "search_corner_turn2");
        step(0, 1, 0, 0, F, "search_corner_front");

        // Mid-removal reset, then SEARCH with left=1, head=0 follows immediately.
        step(1, 0, 0, 1, R, "pre_reset_remove");
        reset = 1'b0;
        #1;
        exp_q.push_back(Z);
        tag_q.push_back("async_reset_remove");
        compare();
        bus.head = 1'b0; bus.left = 1'b1; bus.under = 1'b0; bus.barrier = 1'b0;
        reset = 1'b1;
        step(0, 1, 0, 0, F, "search_left_front");

        // Goal with barrier: under wins, STOPPED is absorbing.
        step(0, 1, 1, 1, Z, "goal_under_barrier");
        step(0, 0, 0, 0, Z, "stopped_idle0");
        step(1, 0, 0, 0, Z, "stopped_idle1");
        step(0, 0, 0, 1, Z, "stopped_barrier");

        // Only reset leaves STOPPED.
        reset = 1'b0;
        #1;
        exp_q.push_back(Z);
        tag_q.push_back("stopped_reset");
        compare();
        bus.head = 1'b0; bus.left = 1'b0; bus.under = 1'b0; bus.barrier = 1'b0;
        reset = 1'b1;
        step(0, 0, 0, 0, F, "post_stop_front");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
